// File: rtl/iter_2d_if.sv
// Coordinate stream and control bundle for the 2-D index generator.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never depends on ready.
interface iter_2d_if #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_WIDTH = $clog2(X_MAX + 1),
  parameter int Y_WIDTH = $clog2(Y_MAX + 1)
);
  logic               start;
  logic [X_WIDTH-1:0] x_limit;
  logic [Y_WIDTH-1:0] y_limit;
  logic               ready;
  logic               valid;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic               last_x;
  logic               last;
  logic               busy;
  logic               done;

  // master = the generator, slave = the controller/consumer that drives it
  modport master (
    input  start, x_limit, y_limit, ready,
    output valid, x, y, last_x, last, busy, done
  );

  modport slave (
    output start, x_limit, y_limit, ready,
    input  valid, x, y, last_x, last, busy, done
  );
endinterface

// File: rtl/iter_2d.sv
// Runtime-bounded 2-D index generator: emits (x, y) in row-major order as a valid/ready
// stream with row/frame markers, a busy flag and a one-cycle completion pulse.
module iter_2d #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_WIDTH = $clog2(X_MAX + 1),
  parameter int Y_WIDTH = $clog2(Y_MAX + 1)
) (
  input  logic        clk,
  input  logic        reset,
  iter_2d_if.master   bus,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_WIDTH-1:0] X_CEIL = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_CEIL = Y_WIDTH'(Y_MAX);

  state_t             state_q;
  logic               valid_q;
  logic [X_WIDTH-1:0] x_q;
  logic [Y_WIDTH-1:0] y_q;
  logic [X_WIDTH-1:0] lim_x_q;
  logic [Y_WIDTH-1:0] lim_y_q;
  logic               last_x_q;
  logic               last_q;
  logic               busy_q;
  logic               done_q;

  logic [X_WIDTH-1:0] lim_x_d;
  logic [Y_WIDTH-1:0] lim_y_d;
  logic [X_WIDTH-1:0] x_inc;
  logic [Y_WIDTH-1:0] y_inc;
  logic               handshake;

  // Out-of-range limits are clamped so the counters stay inside their ceilings.
  always_comb begin
    lim_x_d   = (bus.x_limit > X_CEIL) ? X_CEIL : bus.x_limit;
    lim_y_d   = (bus.y_limit > Y_CEIL) ? Y_CEIL : bus.y_limit;
    x_inc     = x_q + X_WIDTH'(1);
    y_inc     = y_q + Y_WIDTH'(1);
    handshake = valid_q & bus.ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      lim_x_q  <= '0;
      lim_y_q  <= '0;
      last_x_q <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            lim_x_q  <= lim_x_d;
            lim_y_q  <= lim_y_d;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            // Markers are precomputed so they are registered alongside the coordinate.
            last_x_q <= (lim_x_d == '0);
            last_q   <= (lim_x_d == '0) && (lim_y_d == '0);
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (last_q) begin
              valid_q  <= 1'b0;
              last_x_q <= 1'b0;
              last_q   <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (!last_x_q) begin
              x_q      <= x_inc;
              last_x_q <= (x_inc == lim_x_q);
              last_q   <= (x_inc == lim_x_q) && (y_q == lim_y_q);
            end else begin
              x_q      <= '0;
              y_q      <= y_inc;
              last_x_q <= (lim_x_q == '0);
              last_q   <= (lim_x_q == '0) && (y_inc == lim_y_q);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.valid  = valid_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.last_x = last_x_q;
  assign bus.last   = last_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign state_o    = state_q;

  limits_in_range_a: assert property (
    @(posedge clk) disable iff (!reset)
    (state_q == IDLE && bus.start) |-> (bus.x_limit <= X_CEIL && bus.y_limit <= Y_CEIL)
  );

endmodule
